// File: rtl/local_mem_avmm_fifo_bridge.sv
// Avalon-MM pipeline bridge between the AFU memory master (s0) and the EMIF slave (m0).
// Commands pass through an early-waitrequest FIFO; reads are credit-limited toward the EMIF.
module local_mem_avmm_fifo_bridge #(
  parameter int DATA_WIDTH        = 512,
  parameter int SYMBOL_WIDTH      = 8,
  parameter int ADDR_WIDTH        = 27,
  parameter int BURSTCOUNT_WIDTH  = 7,
  parameter int RESPONSE_WIDTH    = 2,
  parameter int CMD_FIFO_DEPTH    = 8,
  parameter int MAX_RD_BEATS      = 256,
  parameter int RSP_PIPE_DEPTH    = 1,
  localparam int BYTEEN_WIDTH     = DATA_WIDTH / SYMBOL_WIDTH,
  localparam int LEVEL_WIDTH      = $clog2(CMD_FIFO_DEPTH) + 1,
  localparam int OUTST_WIDTH      = $clog2(MAX_RD_BEATS) + 1
) (
  input  logic                        clk,
  input  logic                        reset,

  output logic                        s0_waitrequest,
  input  logic                        s0_read,
  input  logic                        s0_write,
  input  logic [ADDR_WIDTH-1:0]       s0_address,
  input  logic [BURSTCOUNT_WIDTH-1:0] s0_burstcount,
  input  logic [DATA_WIDTH-1:0]       s0_writedata,
  input  logic [BYTEEN_WIDTH-1:0]     s0_byteenable,
  output logic [DATA_WIDTH-1:0]       s0_readdata,
  output logic                        s0_readdatavalid,
  output logic [RESPONSE_WIDTH-1:0]   s0_response,

  input  logic                        m0_waitrequest,
  output logic                        m0_read,
  output logic                        m0_write,
  output logic [ADDR_WIDTH-1:0]       m0_address,
  output logic [BURSTCOUNT_WIDTH-1:0] m0_burstcount,
  output logic [DATA_WIDTH-1:0]       m0_writedata,
  output logic [BYTEEN_WIDTH-1:0]     m0_byteenable,
  input  logic [DATA_WIDTH-1:0]       m0_readdata,
  input  logic                        m0_readdatavalid,
  input  logic [RESPONSE_WIDTH-1:0]   m0_response,

  output logic [LEVEL_WIDTH-1:0]      cmd_fifo_level,
  output logic [OUTST_WIDTH-1:0]      rd_outstanding,
  output logic                        rsp_underflow_err
);

  localparam int PTR_WIDTH    = $clog2(CMD_FIFO_DEPTH);
  localparam int ENTRY_WIDTH  = 1 + ADDR_WIDTH + BURSTCOUNT_WIDTH + DATA_WIDTH + BYTEEN_WIDTH;
  localparam int CREDIT_WIDTH = OUTST_WIDTH + 2;
  localparam logic [CREDIT_WIDTH-1:0] CREDIT_MAX = CREDIT_WIDTH'(MAX_RD_BEATS);
  localparam logic [LEVEL_WIDTH-1:0]  LEVEL_HIGH = LEVEL_WIDTH'(CMD_FIFO_DEPTH - 1);

  logic [ENTRY_WIDTH-1:0]      fifo_mem [CMD_FIFO_DEPTH];
  logic [PTR_WIDTH-1:0]        wr_ptr;
  logic [PTR_WIDTH-1:0]        rd_ptr;
  logic [LEVEL_WIDTH-1:0]      level;
  logic [LEVEL_WIDTH-1:0]      level_next;

  logic                        push;
  logic                        pop;
  logic                        stage_free;
  logic                        credit_ok;
  logic [CREDIT_WIDTH-1:0]     stage_beats;
  logic [CREDIT_WIDTH-1:0]     credit_need;

  logic                        head_is_write;
  logic [ADDR_WIDTH-1:0]       head_address;
  logic [BURSTCOUNT_WIDTH-1:0] head_burstcount;
  logic [DATA_WIDTH-1:0]       head_writedata;
  logic [BYTEEN_WIDTH-1:0]     head_byteenable;

  logic                        rd_accept;
  logic                        underflow;
  logic [OUTST_WIDTH-1:0]      rd_inc;
  logic [OUTST_WIDTH-1:0]      rd_dec;

  logic                        rsp_valid_q [RSP_PIPE_DEPTH];
  logic [DATA_WIDTH-1:0]       rsp_data_q  [RSP_PIPE_DEPTH];
  logic [RESPONSE_WIDTH-1:0]   rsp_resp_q  [RSP_PIPE_DEPTH];

  assign push = (s0_read | s0_write) & ~s0_waitrequest;
  assign {head_is_write, head_address, head_burstcount, head_writedata, head_byteenable} =
    fifo_mem[rd_ptr];

  // A read currently held in the output stage has not yet been counted in rd_outstanding,
  // so its beats are reserved here to keep the cap exact.
  always_comb begin
    stage_beats = m0_read ? CREDIT_WIDTH'(m0_burstcount) : '0;
    credit_need = CREDIT_WIDTH'(rd_outstanding) + CREDIT_WIDTH'(head_burstcount) + stage_beats;
    credit_ok   = (credit_need <= CREDIT_MAX);
    stage_free  = ~(m0_read | m0_write) | ~m0_waitrequest;
    pop         = (level != '0) & stage_free & (head_is_write | credit_ok);
    level_next  = level + LEVEL_WIDTH'(push) - LEVEL_WIDTH'(pop);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {s0_write, s0_address, s0_burstcount, s0_writedata, s0_byteenable};
    end
  end

  // Waitrequest rises one entry early so a command already on the bus always has a slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      level          <= '0;
      s0_waitrequest <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_WIDTH'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_WIDTH'(1);
      level          <= level_next;
      s0_waitrequest <= (level_next >= LEVEL_HIGH);
    end
  end

  assign cmd_fifo_level = level;

  always_ff @(posedge clk) begin
    if (reset) begin
      m0_read  <= 1'b0;
      m0_write <= 1'b0;
    end else if (stage_free) begin
      m0_read  <= pop & ~head_is_write;
      m0_write <= pop & head_is_write;
    end
  end

  always_ff @(posedge clk) begin
    if (pop) begin
      m0_address    <= head_address;
      m0_burstcount <= head_burstcount;
      m0_writedata  <= head_writedata;
      m0_byteenable <= head_byteenable;
    end
  end

  always_comb begin
    rd_accept = m0_read & ~m0_waitrequest;
    rd_inc    = rd_accept ? OUTST_WIDTH'(m0_burstcount) : '0;
    underflow = m0_readdatavalid & (rd_outstanding == '0);
    rd_dec    = OUTST_WIDTH'(m0_readdatavalid & ~underflow);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_outstanding    <= '0;
      rsp_underflow_err <= 1'b0;
    end else begin
      rd_outstanding <= rd_outstanding + rd_inc - rd_dec;
      if (underflow) rsp_underflow_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < RSP_PIPE_DEPTH; i++) rsp_valid_q[i] <= 1'b0;
    end else begin
      rsp_valid_q[0] <= m0_readdatavalid;
      for (int i = 1; i < RSP_PIPE_DEPTH; i++) rsp_valid_q[i] <= rsp_valid_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    rsp_data_q[0] <= m0_readdata;
    rsp_resp_q[0] <= m0_response;
    for (int i = 1; i < RSP_PIPE_DEPTH; i++) begin
      rsp_data_q[i] <= rsp_data_q[i-1];
      rsp_resp_q[i] <= rsp_resp_q[i-1];
    end
  end

  assign s0_readdatavalid = rsp_valid_q[RSP_PIPE_DEPTH-1];
  assign s0_readdata      = rsp_data_q[RSP_PIPE_DEPTH-1];
  assign s0_response      = rsp_resp_q[RSP_PIPE_DEPTH-1];

endmodule

// File: tb/tb_local_mem_avmm_fifo_bridge.sv
// Bench for local_mem_avmm_fifo_bridge: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_local_mem_avmm_fifo_bridge;

  localparam int DW = 32;
  localparam int AW = 27;
  localparam int BW = 4;
  localparam int DEPTH = 8;
  localparam int MAXB = 8;
  localparam int RSPD = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic s0_waitrequest, s0_read = 0, s0_write = 0;
  logic [AW-1:0] s0_address = '0;
  logic [BW-1:0] s0_burstcount = '0;
  logic [DW-1:0] s0_writedata = '0;
  logic [3:0] s0_byteenable = '0;
  logic [DW-1:0] s0_readdata;
  logic s0_readdatavalid;
  logic [1:0] s0_response;
  logic m0_waitrequest = 0;
  logic m0_read, m0_write;
  logic [AW-1:0] m0_address;
  logic [BW-1:0] m0_burstcount;
  logic [DW-1:0] m0_writedata;
  logic [3:0] m0_byteenable;
  logic [DW-1:0] m0_readdata = '0;
  logic m0_readdatavalid = 0;
  logic [1:0] m0_response = '0;
  logic [3:0] cmd_fifo_level;
  logic [3:0] rd_outstanding;
  logic rsp_underflow_err;

  always #5 clk = ~clk;

  local_mem_avmm_fifo_bridge #(
    .DATA_WIDTH(DW), .SYMBOL_WIDTH(8), .ADDR_WIDTH(AW), .BURSTCOUNT_WIDTH(BW),
    .RESPONSE_WIDTH(2), .CMD_FIFO_DEPTH(DEPTH), .MAX_RD_BEATS(MAXB), .RSP_PIPE_DEPTH(RSPD)
  ) dut (
    .clk(clk), .reset(reset),
    .s0_waitrequest(s0_waitrequest), .s0_read(s0_read), .s0_write(s0_write),
    .s0_address(s0_address), .s0_burstcount(s0_burstcount), .s0_writedata(s0_writedata),
    .s0_byteenable(s0_byteenable), .s0_readdata(s0_readdata),
    .s0_readdatavalid(s0_readdatavalid), .s0_response(s0_response),
    .m0_waitrequest(m0_waitrequest), .m0_read(m0_read), .m0_write(m0_write),
    .m0_address(m0_address), .m0_burstcount(m0_burstcount), .m0_writedata(m0_writedata),
    .m0_byteenable(m0_byteenable), .m0_readdata(m0_readdata),
    .m0_readdatavalid(m0_readdatavalid), .m0_response(m0_response),
    .cmd_fifo_level(cmd_fifo_level), .rd_outstanding(rd_outstanding),
    .rsp_underflow_err(rsp_underflow_err)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: commands as queue entries, outstanding beats as a plain integer.
  typedef struct {
    bit            is_wr;
    logic [AW-1:0] addr;
    logic [BW-1:0] bc;
    logic [DW-1:0] data;
    logic [3:0]    be;
    int            c;
  } cmd_t;

  cmd_t mq[$];
  cmd_t st;
  cmd_t wlog[$];
  bit   st_v = 0;
  bit   model_on = 0;
  bit   m_wr = 1;
  bit   m_err = 0;
  int   m_out = 0;
  int   cyc = 0;
  int   n_push = 0;
  int   n_rd = 0;
  int   n_wr = 0;
  bit   pv [RSPD];
  logic [DW-1:0] pd [RSPD];
  logic [1:0]    pr [RSPD];

  always @(posedge clk) begin
    bit push, pop, free;
    int beats, old;
    cmd_t nc;
    if (reset) begin
      mq.delete();
      st_v = 0; m_out = 0; m_err = 0; m_wr = 1; model_on = 1;
      for (int i = 0; i < RSPD; i++) pv[i] = 0;
    end else begin
      for (int i = RSPD-1; i > 0; i--) begin
        pv[i] = pv[i-1]; pd[i] = pd[i-1]; pr[i] = pr[i-1];
      end
      pv[0] = m0_readdatavalid; pd[0] = m0_readdata; pr[0] = m0_response;
      push  = (s0_read || s0_write) && !m_wr;
      free  = !st_v || !m0_waitrequest;
      beats = (st_v && !st.is_wr) ? int'(st.bc) : 0;
      old   = m_out;
      pop   = 0;
      if (mq.size() > 0 && free)
        if (mq[0].is_wr || (m_out + int'(mq[0].bc) + beats <= MAXB)) pop = 1;
      if (st_v && !m0_waitrequest) begin
        st.c = cyc;
        if (st.is_wr) begin wlog.push_back(st); n_wr++; end
        else begin n_rd++; m_out += int'(st.bc); end
      end
      if (m0_readdatavalid) begin
        if (old == 0) m_err = 1;
        else m_out -= 1;
      end
      if (free) begin
        st_v = pop;
        if (pop) st = mq.pop_front();
      end
      if (push) begin
        nc.is_wr = s0_write; nc.addr = s0_address; nc.bc = s0_burstcount;
        nc.data = s0_writedata; nc.be = s0_byteenable; nc.c = cyc;
        mq.push_back(nc);
        n_push++;
      end
      m_wr = (mq.size() >= DEPTH-1);
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (model_on) begin
      chk("s0_waitrequest", s0_waitrequest, m_wr);
      chk("m0_read", m0_read, st_v && !st.is_wr);
      chk("m0_write", m0_write, st_v && st.is_wr);
      if (st_v) begin
        chk("m0_address", m0_address, st.addr);
        chk("m0_burstcount", m0_burstcount, st.bc);
        chk("m0_writedata", m0_writedata, st.data);
        chk("m0_byteenable", m0_byteenable, st.be);
      end
      chk("cmd_fifo_level", cmd_fifo_level, mq.size());
      chk("rd_outstanding", rd_outstanding, m_out);
      chk("rsp_underflow_err", rsp_underflow_err, m_err);
      chk("s0_readdatavalid", s0_readdatavalid, pv[RSPD-1]);
      if (pv[RSPD-1]) begin
        chk("s0_readdata", s0_readdata, pd[RSPD-1]);
        chk("s0_response", s0_response, pr[RSPD-1]);
      end
    end
  end

  // Called on a negedge; returns on the negedge after the command is accepted.
  task automatic s0_cmd(input bit wr, input logic [AW-1:0] a, input logic [BW-1:0] bc,
                        input logic [DW-1:0] d, output int acc_cyc);
    int n = 0;
    s0_read = !wr; s0_write = wr; s0_address = a; s0_burstcount = bc;
    s0_writedata = d; s0_byteenable = wr ? d[3:0] | 4'h1 : 4'hF;
    while (s0_waitrequest && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) chk("s0_accept_timeout", 1, 0);
    acc_cyc = cyc;
    @(negedge clk);
    s0_read = 0; s0_write = 0;
  endtask

  task automatic m0_ret(input logic [DW-1:0] d, input logic [1:0] r);
    m0_readdatavalid = 1; m0_readdata = d; m0_response = r;
    @(negedge clk);
    m0_readdatavalid = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t0, tmp, n;

    // 1: reset and idle
    repeat (3) @(negedge clk);
    chk("t1 wait_in_reset", s0_waitrequest, 1);
    chk("t1 m0_read", m0_read, 0);
    chk("t1 m0_write", m0_write, 0);
    chk("t1 level", cmd_fifo_level, 0);
    chk("t1 outstanding", rd_outstanding, 0);
    reset = 0;
    @(negedge clk);
    chk("t1 wait_after_reset", s0_waitrequest, 0);
    idle(4);
    chk("t1 wait_idle", s0_waitrequest, 0);

    // 2: write burst of 4
    wlog.delete();
    s0_cmd(1, 27'h100, 4, 0, t0);
    for (int i = 1; i < 4; i++) s0_cmd(1, 27'h100, 4, i, tmp);
    idle(5);
    chk("t2 beats", wlog.size(), 4);
    for (int i = 0; i < 4 && i < wlog.size(); i++) begin
      chk("t2 data", wlog[i].data, i);
      chk("t2 bc", wlog[i].bc, 4);
      chk("t2 addr", wlog[i].addr, 27'h100);
    end
    if (wlog.size() > 0) chk("t2 latency", wlog[0].c - t0, 2);

    // 3: backpressure fills FIFO to DEPTH-1
    wlog.delete();
    n_push = 0;
    m0_waitrequest = 1;
    fork
      begin
        for (int i = 0; i < 9; i++) s0_cmd(1, 27'h200 + i, 1, 32'h30 + i, tmp);
      end
      begin
        n = 0;
        while (mq.size() != 7 && n < 60) begin @(negedge clk); n++; end
        idle(3);
        chk("t3 level", cmd_fifo_level, 7);
        chk("t3 wait", s0_waitrequest, 1);
        chk("t3 accepted", n_push, 8);
        m0_waitrequest = 0;
      end
    join
    idle(12);
    chk("t3 drained", wlog.size(), 9);
    for (int i = 0; i < wlog.size(); i++) chk("t3 order", wlog[i].data, 32'h30 + i);

    // 4: read credit limit
    n_rd = 0;
    s0_cmd(0, 27'h400, 4, 0, tmp);
    s0_cmd(0, 27'h404, 4, 0, tmp);
    s0_cmd(0, 27'h408, 4, 0, tmp);
    idle(6);
    chk("t4 outstanding_full", rd_outstanding, 8);
    chk("t4 issued", n_rd, 2);
    chk("t4 held", cmd_fifo_level, 1);
    for (int i = 0; i < 4; i++) m0_ret(32'h40 + i, 0);
    idle(4);
    chk("t4 issued_after", n_rd, 3);
    chk("t4 outstanding_after", rd_outstanding, 8);
    for (int i = 0; i < 8; i++) m0_ret(32'h50 + i, 0);
    idle(5);
    chk("t4 drained", rd_outstanding, 0);

    // 5: same-cycle accept and return, response pipeline latency
    s0_cmd(0, 27'h500, 4, 0, tmp);
    idle(4);
    m0_ret(32'h11, 0);
    chk("t5 outstanding3", rd_outstanding, 3);
    s0_cmd(0, 27'h504, 2, 0, tmp);
    n = 0;
    while (!m0_read && n < 10) begin @(negedge clk); n++; end
    chk("t5 m0_read_seen", m0_read, 1);
    m0_ret(32'hA5A5A5A5, 2'b01);
    chk("t5 outstanding_net", rd_outstanding, 4);
    @(negedge clk);
    chk("t5 rdv_early", s0_readdatavalid, 0);
    @(negedge clk);
    chk("t5 rdv", s0_readdatavalid, 1);
    chk("t5 readdata", s0_readdata, 32'hA5A5A5A5);
    chk("t5 response", s0_response, 2'b01);
    for (int i = 0; i < 4; i++) m0_ret(32'h60 + i, 0);
    idle(5);
    chk("t5 drained", rd_outstanding, 0);

    // 6: reset mid-operation
    s0_cmd(0, 27'h600, 1, 0, tmp);
    s0_cmd(0, 27'h601, 1, 0, tmp);
    idle(4);
    chk("t6 outstanding2", rd_outstanding, 2);
    m0_waitrequest = 1;
    for (int i = 0; i < 3; i++) s0_cmd(1, 27'h610 + i, 1, 32'h70 + i, tmp);
    idle(3);
    chk("t6 queued", cmd_fifo_level, 2);
    n_wr = 0;
    reset = 1;
    @(negedge clk);
    reset = 0;
    m0_waitrequest = 0;
    idle(6);
    chk("t6 no_write", n_wr, 0);
    chk("t6 m0_write", m0_write, 0);
    chk("t6 level", cmd_fifo_level, 0);
    chk("t6 outstanding", rd_outstanding, 0);
    m0_ret(32'h80, 0);
    m0_ret(32'h81, 0);
    idle(2);
    chk("t6 err", rsp_underflow_err, 1);
    chk("t6 outstanding_sat", rd_outstanding, 0);
    idle(5);
    chk("t6 err_sticky", rsp_underflow_err, 1);
    reset = 1;
    @(negedge clk);
    reset = 0;
    @(negedge clk);
    chk("t6 err_cleared", rsp_underflow_err, 0);
    idle(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
